score_accum: RTL

Accumulates the performance penalty score for learning mode: while a song plays, counts clock cycles in which the player's keys differ from the expected keys and adds a fixed penalty for every note never hit. Sits between the song playback / key-scan logic and `score2level`, which turns the finished 32-bit score into a BAD/SOSO/GOOD display code. Higher score means worse playing. A score of 0 is a perfect run.

---
 rtl/score_accum_pkg.sv | 18 +
 rtl/score_accum_sat_add32.sv | 25 ++
 rtl/score_accum.sv | 106 ++++++++++
 3 files changed

// File: rtl/score_accum_pkg.sv
// rtl/score_accum_pkg.sv - shared state codes and score limits for score_accum
//
// Purpose: the FSM state encoding used by score_accum, the saturation ceiling
//          for the 32-bit score, and the default miss penalty.
// Ports:   none (package)
package score_accum_pkg;

    typedef enum logic [1:0] {
        SCORE_IDLE = 2'd0,
        SCORE_PLAY = 2'd1,
        SCORE_DONE = 2'd2
    } score_state_e;

    localparam logic [31:0] SCORE_MAX        = 32'hFFFF_FFFF;
    // 0.1 s at the 100 MHz system clock
    localparam logic [31:0] MISS_PENALTY_DEF = 32'd10_000_000;

endpackage

// File: rtl/score_accum_sat_add32.sv
// rtl/score_accum_sat_add32.sv - combinational a + b + c clamped to SCORE_MAX
//
// Purpose: saturating three-term adder used for the score update. The sum is
//          formed in 33 bits; any carry out of bit 31 clamps the result.
// Ports:
//   a_i   in  32  running value
//   b_i   in  32  second addend
//   c_i   in  1   single-bit increment
//   sum_o out 32  saturated sum
module sat_add32
    import score_accum_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] sum_o
);

    logic [32:0] sum_wide;

    // a + b + 1 never exceeds 2^33 - 1, so 33 bits hold the exact sum.
    assign sum_wide = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c_i};
    assign sum_o    = sum_wide[32] ? SCORE_MAX : sum_wide[31:0];

endmodule

// File: rtl/score_accum.sv
// rtl/score_accum.sv - learning-mode penalty score accumulator
//
// Purpose: while a song plays, adds 1 per cycle where key_in differs from
//          expected_key and MISS_PENALTY per note window never matched.
//          The final score feeds score2level.
// Ports:
//   clk           in  1      system clock
//   rst_n         in  1      synchronous active-low reset
//   song_start    in  1      clears score and enters PLAY (highest priority)
//   song_end      in  1      closes the last window, enters DONE
//   note_valid    in  1      closes the current window, opens the next
//   expected_key  in  KEY_W  required key pattern (0 = rest)
//   key_in        in  KEY_W  debounced key state
//   score         out 32     saturating accumulated penalty
//   score_valid   out 1      high in DONE
//   notes_missed  out 8      saturating count of missed windows
module score_accum
    import score_accum_pkg::*;
#(
    parameter logic [31:0] MISS_PENALTY = MISS_PENALTY_DEF,
    parameter int          KEY_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             song_start,
    input  logic             song_end,
    input  logic             note_valid,
    input  logic [KEY_W-1:0] expected_key,
    input  logic [KEY_W-1:0] key_in,
    output logic [31:0]      score,
    output logic             score_valid,
    output logic [7:0]       notes_missed
);

    score_state_e state_q;
    logic [31:0]  score_q;
    logic [31:0]  score_d;
    logic         valid_q;
    logic [7:0]   missed_q;
    logic         hit_q;

    logic        match;
    logic        win_close;
    logic        miss;
    logic [31:0] penalty;

    assign match     = (key_in == expected_key);
    assign win_close = note_valid | song_end;
    // A window is missed only if no earlier cycle hit and the closing cycle
    // itself does not match either.
    assign miss      = win_close & ~hit_q & ~match;
    assign penalty   = miss ? MISS_PENALTY : 32'd0;

    sat_add32 u_sat_add (
        .a_i   (score_q),
        .b_i   (penalty),
        .c_i   (~match),
        .sum_o (score_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SCORE_IDLE;
            score_q  <= 32'd0;
            valid_q  <= 1'b0;
            missed_q <= 8'd0;
            hit_q    <= 1'b0;
        end else if (song_start) begin
            // Coincident song_end / note_valid are deliberately dropped here.
            state_q  <= SCORE_PLAY;
            score_q  <= 32'd0;
            valid_q  <= 1'b0;
            missed_q <= 8'd0;
            hit_q    <= 1'b0;
        end else begin
            case (state_q)
                SCORE_PLAY: begin
                    score_q <= score_d;
                    if (win_close) begin
                        hit_q <= 1'b0;
                        if (miss && missed_q != 8'hFF) begin
                            missed_q <= missed_q + 8'd1;
                        end
                    end else if (match) begin
                        hit_q <= 1'b1;
                    end
                    if (song_end) begin
                        state_q <= SCORE_DONE;
                        valid_q <= 1'b1;
                    end
                end
                SCORE_IDLE, SCORE_DONE: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= SCORE_IDLE;
                end
            endcase
        end
    end

    assign score        = score_q;
    assign score_valid  = valid_q;
    assign notes_missed = missed_q;

endmodule
